// File: rtl/pipeline_pkg.sv
// Shared definitions for the instruction-side pipeline blocks.
//   - default line/page geometry for the next-line prefetcher
//   - iprefetch_state_t: prefetcher control states
//   - line_addr(): clears the in-line offset bits of a byte address
package pipeline_pkg;

    localparam int unsigned DEFAULT_LINE_BYTES = 32;
    localparam int unsigned DEFAULT_LINE_WIDTH = 8 * DEFAULT_LINE_BYTES;
    localparam int unsigned DEFAULT_PAGE_BYTES = 4096;

    typedef enum logic [1:0] {
        StIdle,
        StDemand,
        StResp,
        StPrefetch
    } iprefetch_state_t;

    function automatic logic [31:0] line_addr(input logic [31:0] addr,
                                              input int unsigned offset_bits);
        logic [31:0] mask;
        mask = ~((32'd1 << offset_bits) - 32'd1);
        return addr & mask;
    endfunction

endpackage

// File: rtl/iprefetch_stats.sv
// Saturating event counters for the instruction prefetch buffer.
// Ports:
//   clk, rst            clock, synchronous active-high reset (counters clear to 0)
//   hit_inc             one-cycle strobe: response served without a demand fetch
//   miss_inc            one-cycle strobe: demand fetch started
//   pf_inc              one-cycle strobe: prefetch started
//   stat_hits/misses/prefetches  32-bit counts, held at all-ones once reached
module iprefetch_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        hit_inc,
    input  logic        miss_inc,
    input  logic        pf_inc,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses,
    output logic [31:0] stat_prefetches
);

    logic [31:0] hits_q, misses_q, pfs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hits_q   <= '0;
            misses_q <= '0;
            pfs_q    <= '0;
        end else begin
            if (hit_inc && (hits_q != '1)) hits_q <= hits_q + 32'd1;
            if (miss_inc && (misses_q != '1)) misses_q <= misses_q + 32'd1;
            if (pf_inc && (pfs_q != '1)) pfs_q <= pfs_q + 32'd1;
        end
    end

    assign stat_hits       = hits_q;
    assign stat_misses     = misses_q;
    assign stat_prefetches = pfs_q;

endmodule

// File: rtl/iprefetch_buffer.sv
// Single-entry next-line instruction prefetcher between the instruction cache's
// line port and the arbiter. After every line returned to the cache it fetches
// the following line (same page, no address wrap) into a one-line buffer so a
// sequential fetch stream can be served without an arbiter round trip.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   ipmem_address/read        cache line request (held until ipmem_resp)
//   ipmem_rdata/resp          line to cache, one-cycle response pulse
//   pf_address/read           line-aligned read to arbiter (held until pf_resp)
//   pf_rdata/resp             line from arbiter, one-cycle response
//   stat_hits/misses/prefetches  event counters, present only when
//                             IPREFETCH_STATS_EN is defined
module iprefetch_buffer
    import pipeline_pkg::*;
#(
    parameter int unsigned LINE_BYTES = DEFAULT_LINE_BYTES,
    parameter int unsigned LINE_WIDTH = DEFAULT_LINE_WIDTH,
    parameter int unsigned PAGE_BYTES = DEFAULT_PAGE_BYTES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           ipmem_address,
    input  logic                  ipmem_read,
    output logic [LINE_WIDTH-1:0] ipmem_rdata,
    output logic                  ipmem_resp,
    output logic [31:0]           pf_address,
    output logic                  pf_read,
    input  logic [LINE_WIDTH-1:0] pf_rdata,
    input  logic                  pf_resp
`ifdef IPREFETCH_STATS_EN
    ,
    output logic [31:0]           stat_hits,
    output logic [31:0]           stat_misses,
    output logic [31:0]           stat_prefetches
`endif
);

    localparam int unsigned OFFSET    = $clog2(LINE_BYTES);
    localparam int unsigned PAGE_BITS = $clog2(PAGE_BYTES);

    iprefetch_state_t      state_q, state_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic [31:0]           tag_q, tag_d;
    logic [31:0]           req_q, req_d;
    logic [31:0]           pf_q, pf_d;
    logic                  valid_q, valid_d;

    logic [31:0] req_line;
    logic [32:0] next_line;
    logic        next_ok;

    assign req_line  = line_addr(ipmem_address, OFFSET);
    assign next_line = {1'b0, tag_q} + 33'(LINE_BYTES);
    // Carry out means the 32-bit address wrapped; upper bits must stay in the same page.
    assign next_ok   = !next_line[32] && (next_line[31:PAGE_BITS] == tag_q[31:PAGE_BITS]);

    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        tag_d       = tag_q;
        req_d       = req_q;
        pf_d        = pf_q;
        valid_d     = valid_q;
        pf_read     = 1'b0;
        pf_address  = '0;
        ipmem_resp  = 1'b0;
        ipmem_rdata = '0;

        case (state_q)
            StIdle: begin
                if (ipmem_read) begin
                    if (valid_q && (tag_q == req_line)) begin
                        state_d = StResp;
                    end else begin
                        req_d   = req_line;
                        state_d = StDemand;
                    end
                end
            end
            StDemand: begin
                pf_read    = 1'b1;
                pf_address = req_q;
                if (pf_resp) begin
                    line_d  = pf_rdata;
                    tag_d   = req_q;
                    valid_d = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                ipmem_resp  = 1'b1;
                ipmem_rdata = line_q;
                if (next_ok) begin
                    pf_d    = next_line[31:0];
                    valid_d = 1'b0;
                    state_d = StPrefetch;
                end else begin
                    state_d = StIdle;
                end
            end
            StPrefetch: begin
                pf_read    = 1'b1;
                pf_address = pf_q;
                // The prefetch always runs to completion; a pending demand is
                // only evaluated on the cycle its line arrives.
                if (pf_resp) begin
                    line_d  = pf_rdata;
                    tag_d   = pf_q;
                    valid_d = 1'b1;
                    if (ipmem_read && (req_line == pf_q)) begin
                        state_d = StResp;
                    end else if (ipmem_read) begin
                        req_d   = req_line;
                        state_d = StDemand;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            line_q  <= '0;
            tag_q   <= '0;
            req_q   <= '0;
            pf_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            tag_q   <= tag_d;
            req_q   <= req_d;
            pf_q    <= pf_d;
            valid_q <= valid_d;
        end
    end

`ifdef IPREFETCH_STATS_EN
    logic hit_inc, miss_inc, pf_inc;

    // Entry strobes; a hit is any entry to StResp that did not come from a demand fetch.
    assign hit_inc  = (state_d == StResp) && ((state_q == StIdle) || (state_q == StPrefetch));
    assign miss_inc = (state_d == StDemand) && (state_q != StDemand);
    assign pf_inc   = (state_d == StPrefetch) && (state_q != StPrefetch);

    iprefetch_stats u_stats (
        .clk             (clk),
        .rst             (rst),
        .hit_inc         (hit_inc),
        .miss_inc        (miss_inc),
        .pf_inc          (pf_inc),
        .stat_hits       (stat_hits),
        .stat_misses     (stat_misses),
        .stat_prefetches (stat_prefetches)
    );
`endif

endmodule

// File: tb/tb_iprefetch_buffer.sv
// Bench for iprefetch_buffer. The reference model tracks, per request, which
// line the buffer holds and which lines the arbiter must be asked for; the
// arbiter model and a response monitor compare against those queues.
module tb_iprefetch_buffer;

    logic         clk;
    logic         rst;
    logic [31:0]  ipmem_address;
    logic         ipmem_read;
    logic [255:0] ipmem_rdata;
    logic         ipmem_resp;
    logic [31:0]  pf_address;
    logic         pf_read;
    logic [255:0] pf_rdata;
    logic         pf_resp;

    iprefetch_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .ipmem_address (ipmem_address),
        .ipmem_read    (ipmem_read),
        .ipmem_rdata   (ipmem_rdata),
        .ipmem_resp    (ipmem_resp),
        .pf_address    (pf_address),
        .pf_read       (pf_read),
        .pf_rdata      (pf_rdata),
        .pf_resp       (pf_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int pfresp_cyc = -1;
    int arb_lat = 10;

    logic [31:0]  exp_addr[$];
    logic [255:0] exp_data[$];

    // Model: buffer contents and any prefetch the DUT has been committed to.
    logic [31:0] buf_line = '0;
    bit          buf_valid = 0;
    bit          pf_pending = 0;
    logic [31:0] pf_line = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [255:0] line_data(input logic [31:0] a);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = a ^ (32'h9E37_79B9 * 32'(i + 1));
        return d;
    endfunction

    task automatic model_req(input logic [31:0] line);
        logic [32:0] nxt;
        if (pf_pending) begin
            buf_line   = pf_line;
            buf_valid  = 1;
            pf_pending = 0;
        end
        if (!(buf_valid && buf_line == line)) exp_addr.push_back(line);
        buf_line  = line;
        buf_valid = 1;
        nxt = {1'b0, line} + 33'd32;
        if (!nxt[32] && nxt[31:12] == line[31:12]) begin
            exp_addr.push_back(nxt[31:0]);
            pf_pending = 1;
            pf_line    = nxt[31:0];
        end
    endtask

    // Issue one cache request; called at posedge+1, returns at posedge+1.
    task automatic issue(input logic [31:0] addr, input int gap);
        logic [31:0] line;
        int a;
        bit got;
        line = addr & 32'hFFFF_FFE0;
        model_req(line);
        exp_data.push_back(line_data(line));
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        ipmem_address = addr;
        ipmem_read    = 1'b1;
        a = cyc;
        got = 0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (ipmem_resp) begin
                got = 1;
                break;
            end
        end
        check("resp_seen", 256'(got), 256'(1));
        if (got) check("resp_cycle", 256'(cyc), 256'(((a > pfresp_cyc) ? a : pfresp_cyc) + 1));
        @(posedge clk);
        #1;
        ipmem_read = 1'b0;
    endtask

    // Arbiter: checks each read against the expected address queue, then answers.
    initial begin : arbiter
        logic [31:0] a;
        int lat;
        bit aborted;
        pf_resp  = 1'b0;
        pf_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst && pf_read) begin
                a = pf_address;
                check("pf_addr_aligned", 256'(a[4:0]), 256'(0));
                if (exp_addr.size() == 0) check("pf_read_unexpected", 256'(pf_read), 256'(0));
                else check("pf_address", 256'(a), 256'(exp_addr.pop_front()));
                lat = (arb_lat != 0) ? arb_lat : int'($urandom_range(1, 8));
                aborted = 0;
                for (int i = 0; i < lat; i++) begin
                    @(negedge clk);
                    if (rst) begin
                        aborted = 1;
                        break;
                    end
                    check("pf_read_held", 256'(pf_read), 256'(1));
                    check("pf_address_held", 256'(pf_address), 256'(a));
                end
                if (!aborted) begin
                    @(posedge clk);
                    #1;
                    pf_resp    = 1'b1;
                    pf_rdata   = line_data(a);
                    pfresp_cyc = cyc;
                    @(posedge clk);
                    #1;
                    pf_resp  = 1'b0;
                    pf_rdata = '0;
                end
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin : monitor
        logic [255:0] e;
        if (!rst) begin
            if (ipmem_resp) begin
                if (exp_data.size() == 0) begin
                    check("resp_unexpected", 256'(ipmem_resp), 256'(0));
                end else begin
                    e = exp_data.pop_front();
                    check("resp_data", ipmem_rdata, e);
                end
            end else begin
                check("rdata_zero_outside_resp", ipmem_rdata, 256'(0));
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [31:0] addr;
        logic [31:0] prev;
        bit got;
        int r;
        rst           = 1'b1;
        ipmem_read    = 1'b0;
        ipmem_address = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_pf_read", 256'(pf_read), 256'(0));
        check("reset_ipmem_resp", 256'(ipmem_resp), 256'(0));
        check("reset_pf_address", 256'(pf_address), 256'(0));
        check("reset_ipmem_rdata", ipmem_rdata, 256'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed sequence with a fixed 10-cycle arbiter.
        arb_lat = 10;
        issue(32'h6000_0004, 0);     // cold miss, then prefetch 0x6000_0020
        repeat (25) @(posedge clk);
        #1;
        issue(32'h6000_0020, 0);     // hit in buffer, prefetch 0x6000_0040
        issue(32'h6000_0040, 0);     // matches in-flight prefetch
        issue(32'h7000_0000, 0);     // mismatches in-flight prefetch of 0x6000_0060
        issue(32'h6000_0FE0, 3);     // last line of page: no prefetch
        repeat (20) @(posedge clk);
        #1;
        issue(32'hFFFF_FFE0, 0);     // top of address space: no wrap prefetch
        issue(32'hFFFF_FFFC, 2);     // same line again: hit

        // Reset during a demand fetch.
        arb_lat = 20;
        issue(32'h6000_0100, 0);     // leaves prefetch of 0x6000_0120 in flight
        exp_addr.push_back(32'h5000_0040);
        ipmem_address = 32'h5000_0040;
        ipmem_read    = 1'b1;
        got = 0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (pf_read && pf_address == 32'h5000_0040) begin
                got = 1;
                break;
            end
        end
        check("demand_before_reset", 256'(got), 256'(1));
        @(posedge clk);
        #1;
        rst        = 1'b1;
        ipmem_read = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("after_reset_pf_read", 256'(pf_read), 256'(0));
        check("after_reset_ipmem_resp", 256'(ipmem_resp), 256'(0));
        buf_valid  = 0;
        pf_pending = 0;
        @(posedge clk);
        #1;
        arb_lat = 10;
        issue(32'h6000_0120, 0);     // previously prefetched line must miss now

        // Randomized phase.
        arb_lat = 0;
        prev = 32'h6000_0120;
        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 40) addr = prev + 32'd32 + $urandom_range(0, 31);
            else if (r < 50) addr = (prev & 32'hFFFF_FFE0) + $urandom_range(0, 31);
            else if (r < 90) addr = 32'h6000_0000 + 32'($urandom_range(0, 255)) * 32'd32
                                    + $urandom_range(0, 31);
            else addr = 32'hFFFF_FF00 + $urandom_range(0, 255);
            prev = addr & 32'hFFFF_FFE0;
            issue(addr, int'($urandom_range(0, 3)));
        end

        repeat (40) @(posedge clk);
        @(negedge clk);
        check("addr_queue_drained", 256'(exp_addr.size()), 256'(0));
        check("data_queue_drained", 256'(exp_data.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
